// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
//   Shared definitions for the RSA modular-exponentiation control path.
//   - RSA_WIDTH : default operand/modulus width
//   - state_t   : sequencer FSM state encoding (also exported on the debug port)
// -----------------------------------------------------------------------------
package rsa_pkg;

    localparam int RSA_WIDTH = 6;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        BRED   = 4'd1,
        SQ_REQ = 4'd2,
        SQ_RED = 4'd3,
        MU_REQ = 4'd4,
        MU_RED = 4'd5,
        NEXT   = 4'd6,
        FIN    = 4'd7,
        DONE   = 4'd8
    } state_t;

endpackage

// File: rtl/mod_reduce.sv
// -----------------------------------------------------------------------------
// mod_reduce
//   Sequential restoring shift-subtract reducer: remainder = dividend mod modulus.
//   One dividend bit is consumed per cycle, MSB first, so a reduction takes
//   2*WIDTH iterations; done pulses exactly 2*WIDTH+1 cycles after start.
//   modulus must be non-zero.
// Ports
//   clk, reset_n  clock / asynchronous active-low reset
//   start         1-cycle pulse, accepted only while not busy
//   dividend      2*WIDTH-bit value to reduce (sampled with start)
//   modulus       WIDTH-bit modulus (sampled with start)
//   busy          high while a reduction is in progress
//   done          1-cycle pulse; remainder is valid from this cycle until next start
//   remainder     WIDTH-bit result
// -----------------------------------------------------------------------------
module mod_reduce
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     remainder
);

    localparam int CW = $clog2(2*WIDTH+1);

    logic [2*WIDTH-1:0] r_div;
    logic [WIDTH-1:0]   r_mod;
    logic [WIDTH-1:0]   r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    // The running remainder is always < modulus, so after shifting in one
    // dividend bit it fits in WIDTH+1 bits and a single subtract restores it.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_sub;
    logic           w_ge;

    always_comb begin
        w_shift = {r_rem, r_div[2*WIDTH-1]};
        w_sub   = w_shift - {1'b0, r_mod};
        w_ge    = (w_shift >= {1'b0, r_mod});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_mod  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (start) begin
                    r_div  <= dividend;
                    r_mod  <= modulus;
                    r_rem  <= '0;
                    r_cnt  <= CW'(2*WIDTH);
                    r_busy <= 1'b1;
                end
            end else if (r_cnt != '0) begin
                r_rem <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_div <= {r_div[2*WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign remainder = r_rem;

endmodule

// File: rtl/modexp_sequencer.sv
// -----------------------------------------------------------------------------
// modexp_sequencer
//   Computes result = base^exponent mod modulus with left-to-right
//   square-and-multiply. Every square/multiply is issued to an external shared
//   multiplier; each 2*WIDTH product is reduced by the internal mod_reduce.
// Ports
//   clk, reset_n           clock / asynchronous active-low reset
//   start                  1-cycle pulse, accepted only in IDLE
//   base/exponent/modulus  operands, latched on an accepted start
//   busy                   high from the cycle after an accepted start until done
//   done                   1-cycle pulse, result/err valid
//   err                    modulus was zero; cleared on the next accepted start
//   result                 final value, held until the next accepted start
//   mul_req/mul_op_a/b     multiplier request and operands
//   mul_ack/mul_product    multiplier completion and 2*WIDTH product
//   dbg_state              current FSM state
//   dbg_red_busy           reducer busy
//
// Multiplier handshake: mul_req rises one cycle after a REQ state is entered
// and stays high, with mul_op_a/mul_op_b stable, until mul_ack is sampled high;
// it falls the following cycle. mul_product is taken in the mul_ack cycle.
// mul_ack while mul_req is low is ignored. At most one request is outstanding.
// -----------------------------------------------------------------------------
module modexp_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH     = RSA_WIDTH,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 mul_req,
    output logic [WIDTH-1:0]     mul_op_a,
    output logic [WIDTH-1:0]     mul_op_b,
    input  logic                 mul_ack,
    input  logic [2*WIDTH-1:0]   mul_product,
    output state_t               dbg_state,
    output logic                 dbg_red_busy
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_t               r_state;
    logic [WIDTH-1:0]     r_base;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_b;
    logic [IW-1:0]        r_idx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [WIDTH-1:0]     r_result;
    logic                 r_mul_req;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic                 r_red_start;
    logic [2*WIDTH-1:0]   r_red_div;

    logic                 w_red_busy;
    logic                 w_red_done;
    logic [WIDTH-1:0]     w_red_rem;

    mod_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (r_red_start),
        .dividend  (r_red_div),
        .modulus   (r_mod),
        .busy      (w_red_busy),
        .done      (w_red_done),
        .remainder (w_red_rem)
    );

    // Wait states (BRED, SQ_RED, MU_RED, FIN) are entered together with a
    // one-cycle r_red_start pulse; the reducer's done pulse is the only exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_exp       <= '0;
            r_mod       <= '0;
            r_acc       <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= '0;
            r_mul_req   <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_red_start <= 1'b0;
            r_red_div   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_red_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base   <= base;
                        r_exp    <= exponent;
                        r_mod    <= modulus;
                        r_err    <= 1'b0;
                        r_result <= '0;
                        if (modulus == '0) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_busy      <= 1'b1;
                            r_acc       <= WIDTH'(1);
                            r_idx       <= IW'(EXP_WIDTH-1);
                            r_red_div   <= {{WIDTH{1'b0}}, base};
                            r_red_start <= 1'b1;
                            r_state     <= BRED;
                        end
                    end
                end
                BRED: begin
                    if (w_red_done) begin
                        r_b     <= w_red_rem;
                        r_state <= SQ_REQ;
                    end
                end
                SQ_REQ: begin
                    if (!r_mul_req) begin
                        r_mul_req <= 1'b1;
                        r_op_a    <= r_acc;
                        r_op_b    <= r_acc;
                    end else if (mul_ack) begin
                        r_mul_req   <= 1'b0;
                        r_red_div   <= mul_product;
                        r_red_start <= 1'b1;
                        r_state     <= SQ_RED;
                    end
                end
                SQ_RED: begin
                    if (w_red_done) begin
                        r_acc   <= w_red_rem;
                        r_state <= r_exp[r_idx] ? MU_REQ : NEXT;
                    end
                end
                MU_REQ: begin
                    if (!r_mul_req) begin
                        r_mul_req <= 1'b1;
                        r_op_a    <= r_acc;
                        r_op_b    <= r_b;
                    end else if (mul_ack) begin
                        r_mul_req   <= 1'b0;
                        r_red_div   <= mul_product;
                        r_red_start <= 1'b1;
                        r_state     <= MU_RED;
                    end
                end
                MU_RED: begin
                    if (w_red_done) begin
                        r_acc   <= w_red_rem;
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_idx == '0) begin
                        // Final reduction of acc: also makes modulus==1 yield 0
                        r_red_div   <= {{WIDTH{1'b0}}, r_acc};
                        r_red_start <= 1'b1;
                        r_state     <= FIN;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_state <= SQ_REQ;
                    end
                end
                FIN: begin
                    if (w_red_done) begin
                        r_result <= w_red_rem;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign result       = r_result;
    assign mul_req      = r_mul_req;
    assign mul_op_a     = r_op_a;
    assign mul_op_b     = r_op_b;
    assign dbg_state    = r_state;
    assign dbg_red_busy = w_red_busy;

endmodule

// File: tb/tb_modexp_sequencer.sv
module tb_modexp_sequencer;
  import rsa_pkg::*;

  localparam int W = 6;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   base;
  logic [W-1:0]   exponent;
  logic [W-1:0]   modulus;
  logic           busy;
  logic           done;
  logic           err;
  logic [W-1:0]   result;
  logic           mul_req;
  logic [W-1:0]   mul_op_a;
  logic [W-1:0]   mul_op_b;
  logic           mul_ack;
  logic [2*W-1:0] mul_product;
  state_t         dbg_state;
  logic           dbg_red_busy;

  // scoreboard entry: {err, result}
  logic [W:0] exp_q[$];

  int total;
  int bad;
  int done_seen;
  bit req_seen;
  bit rand_delay;
  bit stray_en;
  int m_cnt;
  logic           prev_req;
  logic [W-1:0]   prev_a;
  logic [W-1:0]   prev_b;

  modexp_sequencer #(.WIDTH(W), .EXP_WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base         (base),
    .exponent     (exponent),
    .modulus      (modulus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .result       (result),
    .mul_req      (mul_req),
    .mul_op_a     (mul_op_a),
    .mul_op_b     (mul_op_b),
    .mul_ack      (mul_ack),
    .mul_product  (mul_product),
    .dbg_state    (dbg_state),
    .dbg_red_busy (dbg_red_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- multiplier model ----------------
  initial begin
    mul_ack = 1'b0;
    mul_product = '0;
    m_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mul_ack = 1'b0;
        m_cnt = 0;
      end else if (mul_ack) begin
        mul_ack = 1'b0;
      end else if (mul_req) begin
        if (m_cnt == 0) begin
          mul_ack = 1'b1;
          mul_product = {{W{1'b0}}, mul_op_a} * {{W{1'b0}}, mul_op_b};
          m_cnt = rand_delay ? int'($urandom_range(3, 0)) : 0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else if (stray_en && $urandom_range(2, 0) == 0) begin
        mul_ack = 1'b1;
        mul_product = '1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W:0] e;
    prev_req = 1'b0;
    prev_a = '0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mul_req) req_seen = 1'b1;
        if (mul_req && prev_req) begin
          total++;
          if (mul_op_a !== prev_a || mul_op_b !== prev_b) begin
            bad++;
            $display("FAIL op_stable: a=%0d b=%0d required a=%0d b=%0d", mul_op_a, mul_op_b, prev_a, prev_b);
          end
        end
        if (done) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: result=%0d err=%0d required no done", result, err);
          end else begin
            e = exp_q.pop_front();
            total += 2;
            if (result !== e[W-1:0]) begin
              bad++;
              $display("FAIL result: got %0d required %0d", result, e[W-1:0]);
            end
            if (err !== e[W]) begin
              bad++;
              $display("FAIL err: got %0d required %0d", err, e[W]);
            end
          end
        end
      end
      prev_req = mul_req;
      prev_a = mul_op_a;
      prev_b = mul_op_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e,
                       input logic [W-1:0] m, input logic [W:0] expv);
    @(negedge clk);
    base = b;
    exponent = e;
    modulus = m;
    start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    int k;
    k = 0;
    while (done_seen == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    total++;
    if (done_seen == n0) begin
      bad++;
      $display("FAIL timeout: no done after %0d cycles required done", budget);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] r, input logic er);
    int n0;
    n0 = done_seen;
    issue(b, e, m, {er, r});
    wait_done(n0, 1500);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int k;
    total = 0;
    bad = 0;
    done_seen = 0;
    req_seen = 1'b0;
    rand_delay = 1'b0;
    stray_en = 1'b0;
    start = 1'b0;
    base = '0;
    exponent = '0;
    modulus = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_result", int'(result), 0);
    check("rst_mul_req", int'(mul_req), 0);
    check("rst_op_a", int'(mul_op_a), 0);
    check("rst_op_b", int'(mul_op_b), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic vectors
    run_op(6'd5, 6'd3, 6'd13, 6'd8, 1'b0);
    repeat (3) @(negedge clk);
    check("result_held", int'(result), 8);
    run_op(6'd7, 6'd0, 6'd11, 6'd1, 1'b0);
    run_op(6'd7, 6'd0, 6'd1, 6'd0, 1'b0);
    run_op(6'd60, 6'd5, 6'd61, 6'd60, 1'b0);
    run_op(6'd63, 6'd2, 6'd10, 6'd9, 1'b0);

    // random ack delay plus stray acks while no request is pending
    rand_delay = 1'b1;
    stray_en = 1'b1;
    run_op(6'd60, 6'd5, 6'd61, 6'd60, 1'b0);
    run_op(6'd3, 6'd7, 6'd61, 6'd52, 1'b0);
    rand_delay = 1'b0;
    stray_en = 1'b0;

    // modulus zero
    req_seen = 1'b0;
    run_op(6'd9, 6'd5, 6'd0, 6'd0, 1'b1);
    check("mod0_no_req", int'(req_seen), 0);
    repeat (3) @(negedge clk);
    check("mod0_err_held", int'(err), 1);
    check("mod0_busy", int'(busy), 0);
    run_op(6'd5, 6'd3, 6'd13, 6'd8, 1'b0);

    // start while busy is ignored
    n0 = done_seen;
    issue(6'd5, 6'd3, 6'd13, {1'b0, 6'd8});
    repeat (10) @(negedge clk);
    check("busy_mid", int'(busy), 1);
    base = 6'd2;
    exponent = 6'd1;
    modulus = 6'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, 1500);
    repeat (40) @(negedge clk);
    check("busy_start_one_done", done_seen, n0 + 1);

    // reset during MU_REQ
    issue(6'd5, 6'd3, 6'd13, {1'b0, 6'd8});
    k = 0;
    while (!(mul_req && dbg_state == MU_REQ) && k < 1500) begin
      @(negedge clk);
      k++;
    end
    check("reached_mu_req", int'(mul_req && dbg_state == MU_REQ), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_mul_req", int'(mul_req), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_state", int'(dbg_state), int'(IDLE));
    run_op(6'd2, 6'd6, 6'd61, 6'd3, 1'b0);

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
